// File: rtl/shift_add_multiplier_controller_if.sv
// Request/result bundle between a requesting datapath and the iterative multiplier.
// The master drives start and operands; the slave returns busy, done and the held product.
interface shift_add_multiplier_controller_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_controller.sv
// Unsigned shift-add multiplier: one WIDTH-cell ripple row reused for WIDTH cycles, done pulses WIDTH+1 cycles after accept.
// start is only taken in IDLE or DONE; requests while busy are dropped, not queued.
module shift_add_multiplier_controller #(
  parameter int WIDTH = 8
) (
  input  logic                               clock,
  input  logic                               resetn,
  shift_add_multiplier_controller_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     pp_row;
  logic [WIDTH-1:0]     row_sum;
  logic [WIDTH:0]       carry;

  // Partial-product row: every cell sees the same multiplier LSB.
  assign pp_row = m_q & {WIDTH{q_q[0]}};

  always_comb begin
    carry   = '0;
    row_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row_sum[i]   = acc_q[i] ^ pp_row[i] ^ carry[i];
      carry[i + 1] = (acc_q[i] & pp_row[i]) | (carry[i] & (acc_q[i] ^ pp_row[i]));
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Shift the row result right across acc:q; the consumed multiplier bit falls off q.
        acc_d = {carry[WIDTH], row_sum[WIDTH-1:1]};
        q_d   = {row_sum[0], q_q[WIDTH-1:1]};
        if (cnt_q == '0) begin
          state_d   = DONE;
          product_d = {acc_d, q_d};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_controller.sv
// Directed and random checks of the shift-add multiplier against plain m*q and accept+WIDTH+1 timing.
module tb_shift_add_multiplier_controller;
  localparam int W = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  shift_add_multiplier_controller_if #(.WIDTH(W)) bus ();

  shift_add_multiplier_controller #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] prev_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] aa, bb;
    aa = {{W{1'b0}}, a};
    bb = {{W{1'b0}}, b};
    return aa * bb;
  endfunction

  // One isolated operation: accept at the edge after this negedge, then watch busy/done/product.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q);
    int lat;
    int nb;
    bit ov;
    bit stable;
    logic [2*W-1:0] exp;
    exp    = ref_mul(m, q);
    lat    = 0;
    nb     = 0;
    ov     = 1'b0;
    stable = 1'b1;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clock);
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.busy && bus.done) ov = 1'b1;
      if (bus.busy) nb++;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.product !== prev_prod) stable = 1'b0;
    end
    chk("latency", lat, W + 1);
    chk("busy_cycles", nb, W);
    chk("busy_done_overlap", {31'd0, ov}, 0);
    chk("product_held_in_run", {31'd0, stable}, 1);
    chk("product", {16'd0, bus.product}, {16'd0, exp});
    @(negedge clock);
    chk("done_one_cycle", {31'd0, bus.done}, 0);
    prev_prod = exp;
  endtask

  initial begin
    int d1, d2, ndone;
    bit gap, late_done;

    resetn           = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    prev_prod        = '0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_product", {16'd0, bus.product}, 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    run_op(8'd5, 8'd3);
    run_op(8'd255, 8'd255);
    run_op(8'd0, 8'd200);
    run_op(8'd1, 8'd128);

    // start held high: second operands presented in the done cycle are taken with no gap.
    d1  = 0;
    d2  = 0;
    gap = 1'b0;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.multiplicand = 8'd7;
    bus.multiplier   = 8'd9;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = k;
          chk("b2b_product1", {16'd0, bus.product}, 63);
          bus.multiplicand = 8'd12;
          bus.multiplier   = 8'd12;
        end else begin
          d2 = k;
          chk("b2b_product2", {16'd0, bus.product}, 144);
          bus.start = 1'b0;
          break;
        end
      end else if (d1 != 0 && !bus.busy) begin
        gap = 1'b1;
      end
    end
    chk("b2b_done1_cycle", d1, W + 1);
    chk("b2b_done2_cycle", d2, 2 * (W + 1));
    chk("b2b_no_gap", {31'd0, gap}, 0);
    prev_prod = 16'd144;
    @(negedge clock);
    chk("b2b_idle_after", {31'd0, bus.busy}, 0);

    // A request made while busy is dropped.
    ndone = 0;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.multiplicand = 8'd3;
    bus.multiplier   = 8'd4;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (bus.done) ndone++;
      bus.start = (k == 3);
      if (k == 3) begin
        bus.multiplicand = 8'd100;
        bus.multiplier   = 8'd100;
      end
    end
    chk("ignore_done_count", ndone, 1);
    chk("ignore_product", {16'd0, bus.product}, 12);
    chk("ignore_idle", {31'd0, bus.busy}, 0);

    // Asynchronous reset in the middle of RUN clears everything immediately.
    @(negedge clock);
    bus.start        = 1'b1;
    bus.multiplicand = 8'd200;
    bus.multiplier   = 8'd150;
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 2; k <= 4; k++) @(negedge clock);
    chk("abort_busy_before", {31'd0, bus.busy}, 1);
    resetn = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_done", {31'd0, bus.done}, 0);
    chk("abort_product", {16'd0, bus.product}, 0);
    @(negedge clock);
    resetn    = 1'b1;
    prev_prod = '0;
    late_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (bus.done || bus.busy) late_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, late_done}, 0);
    run_op(8'd6, 8'd7);

    for (int n = 0; n < 1000; n++) begin
      run_op(W'($urandom), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
